decompose_mul_arb: RTL and testbench

DECOMPOSE_MUL_ARB -- requirements
Module: decompose_mul_arb

---
 rtl/decompose_mul_arb.sv | 117 +++++++++++
 tb/tb_decompose_mul_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompose_mul_arb.sv
// decompose_mul_arb: two-requester round-robin front end for a shared,
// single-register unsigned multiplier that lives outside this block.
// One in-flight slot (v1/t1) tracks the product sitting in the multiplier
// register and which requester it belongs to.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. reqN_ready depends combinationally
// on reqN_valid and rsp_ready; rsp_valid/rsp_id come straight from flops.
module decompose_mul_arb #(
  parameter int DIN_W  = 31,
  parameter int DOUT_W = 62
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DIN_W-1:0]  req0_a,
  input  logic [DIN_W-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DIN_W-1:0]  req1_a,
  input  logic [DIN_W-1:0]  req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DOUT_W-1:0] rsp_data,
  output logic [DIN_W-1:0]  mul_din0,
  output logic [DIN_W-1:0]  mul_din1,
  output logic              mul_ce,
  input  logic [DOUT_W-1:0] mul_dout,
  output logic [15:0]       op_count
);

  logic        v1_q, v1_d;
  logic        t1_q, t1_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        advance;
  logic        grant_any;
  logic        grant_idx;

  // Slot can move when empty or when its product is being taken this cycle;
  // the multiplier register only loads when the slot moves.
  assign advance = !v1_q || rsp_ready;
  assign mul_ce  = advance;

  // Arbitration: lone requester wins, contention goes to the one not
  // granted last. No grants while reset is held.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (advance && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_idx = ~last_q;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_idx;
  assign req1_ready = grant_any &&  grant_idx;

  // Operand steering: granted pair to the multiplier, zeros when idle.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (grant_any) begin
      mul_din0 = grant_idx ? req1_a : req0_a;
      mul_din1 = grant_idx ? req1_b : req0_b;
    end
  end

  // Next-state for slot, round-robin pointer and delivered-product counter.
  always_comb begin
    v1_d   = v1_q;
    t1_d   = t1_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (advance) begin
      v1_d = grant_any;
      t1_d = grant_any ? grant_idx : t1_q;
    end
    if (grant_any) begin
      last_d = grant_idx;
    end
    if (v1_q && rsp_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers; reset empties the slot and points arbitration at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      t1_q   <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= 16'd0;
    end else begin
      v1_q   <= v1_d;
      t1_q   <= t1_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rsp_valid = v1_q;
  assign rsp_id    = t1_q;
  assign rsp_data  = mul_dout;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_decompose_mul_arb.sv
// Directed bench for decompose_mul_arb with a behavioural model of the
// shared one-register multiplier hanging off the mul_* ports.
module tb_decompose_mul_arb;

  localparam int DIN_W  = 31;
  localparam int DOUT_W = 62;

  logic              clk;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DIN_W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [DOUT_W-1:0] rsp_data;
  logic [DIN_W-1:0]  mul_din0, mul_din1;
  logic              mul_ce;
  logic [DOUT_W-1:0] mul_dout;
  logic [15:0]       op_count;

  int tests_run;
  int tests_failed;

  decompose_mul_arb #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce), .mul_dout(mul_dout),
    .op_count(op_count)
  );

  // clock / external multiplier model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mul_ce) mul_dout <= DOUT_W'(mul_din0) * DOUT_W'(mul_din1);
  end

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0 || rsp_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rsp_valid=%b op_count=%0d rsp_id=%b, want 0/0/0", rsp_valid, op_count, rsp_id);
    end
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mul_din0 !== '0 || mul_din1 !== '0) begin
      tests_failed++;
      $display("FAIL idle_outputs: r0=%b r1=%b din0=%h din1=%h, want 0/0/0/0", req0_ready, req1_ready, mul_din0, mul_din1);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_a = 31'd3; req0_b = 31'd5;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mul_din0 !== 31'd3 || mul_din1 !== 31'd5) begin
      tests_failed++;
      $display("FAIL single_grant: r0=%b r1=%b din0=%0d din1=%0d, want 1/0/3/5", req0_ready, req1_ready, mul_din0, mul_din1);
    end
    step();
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 62'd15 || op_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL single_rsp: v=%b id=%b data=%0d cnt=%0d, want 1/0/15/0", rsp_valid, rsp_id, rsp_data, op_count);
    end
    step();
    tests_run++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_count: v=%b cnt=%0d, want 0/1", rsp_valid, op_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DOUT_W-1:0] exp_q[$];
    logic [DOUT_W-1:0] exp_d;
    do_reset();
    req0_valid = 1'b1; req0_a = 31'd2; req0_b = 31'd7;
    req1_valid = 1'b1; req1_a = 31'd4; req1_b = 31'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: r0=%b r1=%b, want %b/%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      exp_q.push_back((i % 2 == 0) ? 62'd14 : 62'd36);
      step();
      exp_d = exp_q.pop_front();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== exp_d || op_count !== 16'(i)) begin
        tests_failed++;
        $display("FAIL rr_rsp_%0d: v=%b id=%b data=%0d cnt=%0d, want 1/%0d/%0d/%0d", i, rsp_valid, rsp_id, rsp_data, op_count, i % 2, exp_d, i);
      end
    end
    idle_inputs();
    step();
    tests_run++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL rr_drain: v=%b cnt=%0d, want 0/4", rsp_valid, op_count);
    end
  endtask

  task automatic test_max_operands();
    do_reset();
    req1_valid = 1'b1; req1_a = 31'h7FFFFFFF; req1_b = 31'h7FFFFFFF;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_grant: r0=%b r1=%b, want 0/1", req0_ready, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 62'h3FFFFFFF00000001) begin
      tests_failed++;
      $display("FAIL max_product: v=%b id=%b data=%h, want 1/1/3fffffff00000001", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 31'd6; req0_b = 31'd7;
    step();
    req0_a = 31'd8; req0_b = 31'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (mul_ce !== 1'b0 || req0_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 62'd42 || op_count !== 16'd0) begin
        tests_failed++;
        $display("FAIL stall_%0d: ce=%b r0=%b v=%b data=%0d cnt=%0d, want 0/0/1/42/0", i, mul_ce, req0_ready, rsp_valid, rsp_data, op_count);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (mul_ce !== 1'b1 || req0_ready !== 1'b1 || rsp_data !== 62'd42) begin
      tests_failed++;
      $display("FAIL stall_release: ce=%b r0=%b data=%0d, want 1/1/42", mul_ce, req0_ready, rsp_data);
    end
    step();
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 62'd72 || rsp_id !== 1'b0 || op_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL stall_handover: v=%b data=%0d id=%b cnt=%0d, want 1/72/0/1", rsp_valid, rsp_data, rsp_id, op_count);
    end
  endtask

  task automatic test_pointer_hold();
    do_reset();
    req0_valid = 1'b1; req0_a = 31'd1; req0_b = 31'd1;
    step();
    idle_inputs();
    step();
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL pointer_hold: r0=%b r1=%b, want 0/1", req0_ready, req1_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    req1_valid = 1'b1; req1_a = 31'd5; req1_b = 31'd5;
    step();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: r0=%b r1=%b, want 0/0", req0_ready, req1_ready);
    end
    step();
    reset = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midop: v=%b cnt=%0d r0=%b r1=%b, want 0/0/1/0", rsp_valid, op_count, req0_ready, req1_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_count_wrap();
    do_reset();
    req0_valid = 1'b1; req0_a = 31'd1; req0_b = 31'd2;
    for (int i = 0; i < 65536; i++) step();
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (op_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL count_full: cnt=%h, want ffff", op_count);
    end
    step();
    tests_run++;
    if (op_count !== 16'h0000 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL count_wrap: cnt=%h v=%b, want 0000/0", op_count, rsp_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_max_operands();
    test_stall();
    test_pointer_hold();
    test_reset_midop();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
